// File: rtl/timer_keypad_loader.sv
// Keypad entry stage for the timer's BCD down-counter chain.
// Collects MM:SS digits and pulses load when a valid value is started.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous active-high reset
//   key_valid  keypad strobe level; each 0->1 edge is one key
//   key_code   keypad code, 0-9 digit, 10-15 non-digit
//   start      start request pulse
//   clear      clear request pulse
//   min_tens   BCD digit 3 (leftmost)
//   min_ones   BCD digit 2
//   sec_tens   BCD digit 1
//   sec_ones   BCD digit 0 (rightmost)
//   load       one-cycle parallel-load pulse for the counters
//   digit_cnt  number of digits entered so far
//   err        one-cycle pulse on a rejected key or start
module timer_keypad_loader #(
    parameter int NUM_DIGITS   = 4,
    parameter int SEC_TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       start,
    input  logic       clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       load,
    output logic [2:0] digit_cnt,
    output logic       err
);

    localparam logic [2:0] CNT_MAX = 3'(NUM_DIGITS);
    localparam logic [3:0] ST_MAX  = 4'(SEC_TENS_MAX);

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        LOADED
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [3:0][3:0] dig;
    logic [3:0][3:0] dig_n;
    logic [2:0]      cnt;
    logic [2:0]      cnt_n;
    logic            load_n;
    logic            err_n;
    logic            key_valid_d;
    logic            key_hit;
    logic            is_digit;

    assign key_hit  = key_valid & ~key_valid_d;
    assign is_digit = (key_code < 4'd10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dig         <= '0;
            cnt         <= '0;
            load        <= 1'b0;
            err         <= 1'b0;
            key_valid_d <= 1'b0;
        end else begin
            state       <= state_n;
            dig         <= dig_n;
            cnt         <= cnt_n;
            load        <= load_n;
            err         <= err_n;
            key_valid_d <= key_valid;
        end
    end

    // clear wins over start, start wins over a key in the same cycle;
    // a key that loses to start is simply dropped.
    always_comb begin
        state_n = state;
        dig_n   = dig;
        cnt_n   = cnt;
        load_n  = 1'b0;
        err_n   = 1'b0;
        if (clear) begin
            state_n = IDLE;
            dig_n   = '0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!start && key_hit) begin
                        if (is_digit) begin
                            // fresh entry: upper digits cleared
                            dig_n   = {12'h000, key_code};
                            cnt_n   = 3'd1;
                            state_n = ENTRY;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                ENTRY: begin
                    if (start) begin
                        if (dig[1] <= ST_MAX) begin
                            load_n  = 1'b1;
                            cnt_n   = '0;
                            state_n = LOADED;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else if (key_hit) begin
                        if (!is_digit) begin
                            err_n = 1'b1;
                        end else if (cnt < CNT_MAX) begin
                            dig_n = {dig[2:0], key_code};
                            cnt_n = cnt + 3'd1;
                        end
                    end
                end
                LOADED: begin
                    // digits stay on the outputs until the next entry
                    state_n = IDLE;
                    if (!start && key_hit && !is_digit) begin
                        err_n = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign min_tens  = dig[3];
    assign min_ones  = dig[2];
    assign sec_tens  = dig[1];
    assign sec_ones  = dig[0];
    assign digit_cnt = cnt;

endmodule
